// File: rtl/clk_div_gen_if.sv
// Control and status bundle for clk_div_gen.
// The master drives the enable/ratio controls and the slave returns the divided clock and status.
interface clk_div_gen_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] div_in;
  logic             clk_out;
  logic             tick;
  logic [WIDTH-1:0] cur_div;

  modport master (
    output en, load, div_in,
    input  clk_out, tick, cur_div
  );

  modport slave (
    input  en, load, div_in,
    output clk_out, tick, cur_div
  );
endinterface

// File: rtl/clk_div_gen.sv
// Programmable divider: registered divided clock plus a one-cycle tick on each clk_out rise.
// Ratio changes are deferred to the period boundary, so clk_out never produces a runt pulse.
module clk_div_gen #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic          clk,
  input  logic          rst,
  clk_div_gen_if.slave  bus
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] act_div_q, act_div_d;
  logic [WIDTH-1:0] half_q, half_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             wrap;

  always_comb begin
    cnt_d      = cnt_q;
    act_div_d  = act_div_q;
    half_d     = half_q;
    pend_div_d = pend_div_q;
    tick_d     = 1'b0;
    wrap       = bus.en && (cnt_q == act_div_q - ONE);

    // The wrap consumes pend_div_q as it stood before this edge, even if load is also high now.
    if (bus.load) begin
      pend_div_d = (bus.div_in < MIN_DIV) ? MIN_DIV : bus.div_in;
    end

    if (bus.en) begin
      if (wrap) begin
        cnt_d     = '0;
        act_div_d = pend_div_q;
        half_d    = pend_div_q >> 1;
        tick_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end

    clk_out_d = (cnt_d < half_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= DEF_DIV - ONE;
      act_div_q  <= DEF_DIV;
      half_q     <= DEF_DIV >> 1;
      pend_div_q <= DEF_DIV;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      act_div_q  <= act_div_d;
      half_q     <= half_d;
      pend_div_q <= pend_div_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign bus.clk_out = clk_out_q;
  assign bus.tick    = tick_q;
  assign bus.cur_div = act_div_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboarded bench for clk_div_gen: a period-pattern reference model queues the expected outputs
// for every edge, and a monitor compares them with the DUT one step after each rising clock edge.
`timescale 1ns/1fs
module tb_clk_div_gen;
  localparam int WIDTH = 8;
  localparam int DEF   = 4;
  localparam realtime T_CLK = 1.90625ns;

  typedef struct {
    bit clk_out;
    bit tick;
    int cur_div;
  } exp_t;

  logic clk;
  logic rst;
  clk_div_gen_if #(.WIDTH(WIDTH)) bus ();

  clk_div_gen #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #(T_CLK / 2) clk = ~clk;
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  // Reference model: a period is a list of output levels, floor(N/2) ones then ceil(N/2) zeros.
  bit rem[$];
  int pend_m = DEF;
  int cur_m  = DEF;
  bit out_m  = 1'b0;
  bit tick_m = 1'b0;

  realtime last_clk_rise = 0;
  realtime last_rise     = 0;
  realtime prev_rise     = 0;
  realtime rise_phase    = 0;

  always @(posedge clk) last_clk_rise = $realtime;
  always @(posedge bus.clk_out) begin
    prev_rise  = last_rise;
    last_rise  = $realtime;
    rise_phase = last_rise - last_clk_rise;
  end

  task automatic check(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  task automatic step(bit r, bit e, bit l, int d);
    exp_t x;
    @(negedge clk);
    rst        = r;
    bus.en     = e;
    bus.load   = l;
    bus.div_in = WIDTH'(d);
    if (r) begin
      rem.delete();
      pend_m = DEF;
      cur_m  = DEF;
      out_m  = 1'b0;
      tick_m = 1'b0;
    end else begin
      tick_m = 1'b0;
      if (e) begin
        if (rem.size() == 0) begin
          tick_m = 1'b1;
          cur_m  = pend_m;
          for (int i = 0; i < cur_m / 2; i++) rem.push_back(1'b1);
          for (int i = 0; i < cur_m - cur_m / 2; i++) rem.push_back(1'b0);
        end
        out_m = rem.pop_front();
      end
      if (l) pend_m = (d < 2) ? 2 : d;
    end
    x.clk_out = out_m;
    x.tick    = tick_m;
    x.cur_div = cur_m;
    exp_q.push_back(x);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 0);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #0.1ns;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        check("clk_out", int'(bus.clk_out), int'(x.clk_out));
        check("tick",    int'(bus.tick),    int'(x.tick));
        check("cur_div", int'(bus.cur_div), x.cur_div);
      end
    end
  end

  initial begin : stim
    bit found;
    rst = 1'b1; bus.en = 1'b0; bus.load = 1'b0; bus.div_in = '0;

    // Default ratio after reset
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    run(14);
    @(posedge clk); #0.1ns;
    n_checks++;
    if (last_rise - prev_rise > 7.626ns || last_rise - prev_rise < 7.624ns) begin
      n_fail++;
      $display("FAIL clk_out_period: got %0t, expected 7.625ns", last_rise - prev_rise);
    end
    n_checks++;
    if (rise_phase > 0.001ns || rise_phase < -0.001ns) begin
      n_fail++;
      $display("FAIL clk_out_phase: got %0t, expected 0", rise_phase);
    end

    // Odd ratio
    step(1'b0, 1'b1, 1'b1, 5);
    run(14);

    // Load 3 exactly on a wrap edge while running at 4
    step(1'b0, 1'b1, 1'b1, 4);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (rem.size() == 0 && pend_m == 4 && cur_m == 4) found = 1'b1;
      else run(1);
    end
    check("wrap_edge_reached", int'(found), 1);
    step(1'b0, 1'b1, 1'b1, 3);
    run(12);

    // Clamping of 0 and 1
    step(1'b0, 1'b1, 1'b1, 0);
    step(1'b0, 1'b1, 1'b1, 1);
    run(8);

    // Enable gating in the middle of the high phase at N=6
    step(1'b0, 1'b1, 1'b1, 6);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (cur_m == 6 && out_m && rem.size() != 0 && rem[0]) found = 1'b1;
      else run(1);
    end
    check("mid_high_reached", int'(found), 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0);
    run(14);

    // Reset asserted at cnt = 1 with N = 6
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (cur_m == 6 && rem.size() == 4) found = 1'b1;
      else run(1);
    end
    check("cnt1_reached", int'(found), 1);
    step(1'b1, 1'b1, 1'b1, 7);
    step(1'b1, 1'b0, 1'b0, 0);
    run(12);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int d;
      d = ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 9));
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 9) == 0),
           d);
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Programmable synchronous clock divider and period-tick generator that consumes the buffered clock from `clkbuff` and produces a divided clock plus a one-cycle period strobe for downstream FIFO/RAM test logic. All state is clocked on the rising edge of the single input clock, and every output is registered. Division-ratio changes take effect only at a period boundary, so `clk_out` never produces a runt pulse.

## Interface
- `WIDTH`, default 8: width of the division-ratio bus and counter.
- `DEFAULT_DIV`, default 4: ratio loaded at reset; must be ≥ 2.
- `clk`, input, 1: buffered clock (the `oclk` of `clkbuff`); all logic on posedge.
- `rst`, input, 1: reset, synchronous, active-high.
- `en`, input, 1: count enable.
- `load`, input, 1: capture `div_in` into the pending-ratio register.
- `div_in`, input, WIDTH: requested ratio N.
- `clk_out`, output, 1: divided clock, registered.
- `tick`, output, 1: one-`clk` pulse coincident with each rising edge of `clk_out`.
- `cur_div`, output, WIDTH: ratio currently in effect.

## Operation
- Internal registers:
  - `cnt` (WIDTH bits)
  - `act_div` (ratio in effect)
  - `half` (equal to `act_div >> 1`)
  - `pend_div` (next ratio)
- Loading a ratio: when `load` = 1 on an edge, `pend_div` <= `div_in`. Values 0 or 1 are clamped to 2.
- Counting: on each edge with `en` = 1:
  - If `cnt` == `act_div`-1 (wrap): `cnt` <= 0; `act_div` <= `pend_div`; `half` <= `pend_div` >> 1.
  - Otherwise: `cnt` <= `cnt` + 1.
- Output invariant: after every edge, `clk_out` == (`cnt` < `half`). It is computed from next-state values and registered, not decoded combinationally.
- Duty cycle: high for floor(N/2) cycles, low for ceil(N/2) cycles. N=2 gives 1/1; N=5 gives 2 high, 3 low.
- `tick`: registered; equals 1 for exactly the cycle after a wrap edge, i.e. while `cnt` == 0 and `en` was 1 on that edge.
- `en` = 0: `cnt`, `act_div`, `half` and `clk_out` hold; `tick` <= 0. `load` is still honoured while `en` = 0.
- `load` on the same edge as a wrap: the wrap uses the `pend_div` value from before that edge. The new value applies at the following wrap.
- Multiple `load`s within one period: the last one before the wrap wins.
- `cur_div` = `act_div`.

## Timing
- Reset values (edge with `rst` = 1):
  - `cnt` = `DEFAULT_DIV`-1 (parked at terminal count)
  - `act_div` = `pend_div` = `DEFAULT_DIV`; `half` = `DEFAULT_DIV` >> 1
  - `clk_out` = 0, `tick` = 0, `cur_div` = `DEFAULT_DIV`
- First-edge latency: the first edge with `en` = 1 after reset wraps. `clk_out` and `tick` are 1 in the following cycle, so latency from `en` to first `clk_out` rise is 1 `clk`.
- Period: `clk_out` period = `act_div` `clk` periods, exactly, in steady state.
- Ratio-change latency: a `load` takes effect at the first wrap edge strictly after the `load` edge. `cur_div` changes on that wrap edge.
- `rst` dominates `en` and `load` on the same edge.
- Reset asserted mid-period: on the next edge `clk_out` drops to 0 and the counter re-parks. There is no partial-period completion.
- Counter range: `cnt` never exceeds `act_div`-1. A ratio of 2^WIDTH-1 is legal.

## Test plan
- **Default ratio after reset.** Stimulus: `rst` 2 cycles, then `en` = 1, `clk` period 1.90625 ns. Required response:
  - `clk_out` pattern 1,1,0,0 repeating.
  - `tick` every 4th cycle, first one 1 cycle after `en`.
  - Measured `clk_out` period 7.625 ns; posedge-to-posedge phase of `clk_out` vs `clk` = 0 modulo one `clk` period.
- **Odd ratio.** Stimulus: load 5. Required response: after the next wrap, pattern 1,1,0,0,0, period 5 cycles, `cur_div` = 5.
- **Load on a wrap edge.** Stimulus: load 3 on a wrap edge while running at 4. Required response: one more 4-cycle period, then 3-cycle periods (1 high, 2 low). No `clk_out` high pulse is shorter than 1 cycle.
- **Clamping.** Stimulus: load 0, then load 1. Required response: `cur_div` = 2 after the wrap; `clk_out` toggles every cycle.
- **Enable gating.** Stimulus: drop `en` for 3 cycles in mid-high phase. Required response:
  - `clk_out` holds 1 and `tick` = 0 throughout.
  - On resume, the remaining high count completes, and the total high time over the period is floor(N/2) enabled cycles.
- **Reset mid-operation.** Stimulus: assert `rst` at `cnt` = 1 with N = 6. Required response: `clk_out` = 0, `tick` = 0 and `cur_div` = 4 on the next edge; the restart behaves exactly as in the first scenario.
